// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_pkg
//  Purpose  : Shared types and constants for the seven-segment display
//             arbiter: segment value width, the largest value a two-digit
//             display can show, and the arbiter state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

  localparam int SEG_VALUE_W   = 8;
  // Clamping to this value is done downstream in sevenseg_driver.
  localparam int SEG_MAX_VALUE = 99;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } arb_state_t;

endpackage : sevenseg_pkg
`default_nettype wire

// File: rtl/sevenseg_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_rr_pick
//  Purpose  : Combinational round-robin search. Returns the first set bit of
//             'valid' at or after 'ptr', wrapping modulo NUM_REQ.
//  Ports    : valid     [NUM_REQ-1:0]  request vector
//             ptr       [IDX_W-1:0]    search start index
//             grant_idx [IDX_W-1:0]    selected index (0 when none valid)
//             any_valid                at least one request is set
//  Revision : 1.0 - initial release
// ============================================================================
module sevenseg_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  logic [IDX_W:0] cand;

  // Scan offsets from the farthest to the nearest so the last hit, which
  // is the one closest to ptr, wins.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    any_valid = |valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
        cand = cand - (IDX_W + 1)'(NUM_REQ);
      end
      if (valid[cand[IDX_W-1:0]]) begin
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule : sevenseg_rr_pick
`default_nettype wire

// File: rtl/sevenseg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_display_arbiter
//  Purpose  : Time-shares a two-digit seven-segment display among NUM_REQ
//             requesters. Grants round-robin, captures the granted value and
//             holds it for DWELL_CYCLES clocks, then moves on to the next
//             pending requester with no idle bubble. The display never blanks.
//  Config   : `define SEVENSEG_ARB_PREEMPT_EN makes requester 0 urgent: it
//             preempts any other owner mid-dwell without moving the pointer.
//  Ports    : clk, rst           clock, asynchronous active-high reset
//             req_valid  [N]     per-requester request
//             req_value  [8N]    requester i value at [8i+7:8i]
//             req_ready  [N]     one-cycle grant/capture pulse
//             disp_value [8]     value routed to sevenseg_driver
//             disp_owner         index of current/last shown requester
//             disp_busy          high while a dwell is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module sevenseg_display_arbiter
  import sevenseg_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 25000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [SEG_VALUE_W*NUM_REQ-1:0] req_value,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [SEG_VALUE_W-1:0]         disp_value,
  output logic [$clog2(NUM_REQ)-1:0]     disp_owner,
  output logic                           disp_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  arb_state_t             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       dwell_cnt;

  logic [IDX_W-1:0]       pick_idx;
  logic                   any_valid;
  logic                   preempt;
  logic                   terminal;
  logic                   do_grant;
  logic [IDX_W-1:0]       grant_idx;
  logic [SEG_VALUE_W-1:0] grant_value;
  logic [IDX_W-1:0]       next_ptr;

  sevenseg_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant_idx (pick_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    preempt = 1'b0;
`ifdef SEVENSEG_ARB_PREEMPT_EN
    // An owner of 0 already shows the urgent requester; it waits its turn.
    preempt = (state == SHOW) && req_valid[0] && (disp_owner != '0);
`endif
    terminal  = (state == SHOW) && (dwell_cnt == '0);
    // Arbitration happens in IDLE and on the last dwell cycle, so back-to-back
    // dwells chain without an idle cycle in between.
    do_grant  = preempt || (((state == IDLE) || terminal) && any_valid);
    grant_idx = preempt ? '0 : pick_idx;

    grant_value = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_value = req_value[i*SEG_VALUE_W +: SEG_VALUE_W];
      end
    end

    next_ptr = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      dwell_cnt  <= '0;
      req_ready  <= '0;
      disp_value <= '0;
      disp_owner <= '0;
      disp_busy  <= 1'b0;
    end else begin
      req_ready <= '0;
      if (do_grant) begin
        state      <= SHOW;
        disp_value <= grant_value;
        disp_owner <= grant_idx;
        disp_busy  <= 1'b1;
        req_ready  <= NUM_REQ'(1) << grant_idx;
        dwell_cnt  <= DWELL_LOAD;
        // A preemption leaves the pointer alone so the interrupted rotation
        // resumes where it was.
        if (!preempt) begin
          rr_ptr <= next_ptr;
        end
      end else if (state == SHOW) begin
        if (dwell_cnt == '0) begin
          // Nothing pending: stop the dwell but keep showing the last value.
          state     <= IDLE;
          disp_busy <= 1'b0;
        end else begin
          dwell_cnt <= dwell_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule : sevenseg_display_arbiter
`default_nettype wire
